// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: autonomous scan sequencer in front of the I2C ADC transaction block.
// A free-running tick (every SCAN_DIV clocks while en=1) starts a scan over the enabled
// channels. Each channel gets a dummy read followed by a stored read. A dummy read is
// needed because a read returns the conversion of the previously addressed channel.
// Ports:
//   clk, rst             clock, async active-high reset
//   en, ch_mask, err_clr scan enable, channel enable mask, sticky-error clear
//   wr_req, rd_req, device_id, reg_addr, reg_addr_vld, wr_data, wr_data_vld -> adc
//   rd_data, rd_data_vld                                                     <- adc
//   ch_data, ch_upd      per-channel result registers and one-cycle update strobes
//   busy, timeout_err, overrun_err   status
//
// state      | meaning
// S_IDLE     | waiting for a tick with a non-zero channel mask
// S_SETUP    | load control byte (CTRL_BASE | ch) into the adc
// S_REQ      | one-cycle read request, clear pulse/timeout counters
// S_WAIT_RD  | count rd_data_vld pulses; second pulse or timeout leaves
// S_CAPTURE  | sample rd_data (stored only on the real pass)
// S_GAP_WAIT | GAP idle clocks between transactions
// S_NEXT     | pick next enabled channel or finish the scan
module adc_scan_ctrl #(
   parameter int         NUM_CH    = 4,
   parameter logic [6:0] DEV_ID    = 7'h48,
   parameter logic [7:0] CTRL_BASE = 8'h40,
   parameter int         SCAN_DIV  = 50000,
   parameter int         TIMEOUT   = 100000,
   parameter int         GAP       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [NUM_CH-1:0]   ch_mask,
   input  logic                err_clr,
   output logic                wr_req,
   output logic                rd_req,
   output logic [6:0]          device_id,
   output logic [7:0]          reg_addr,
   output logic                reg_addr_vld,
   output logic [7:0]          wr_data,
   output logic                wr_data_vld,
   input  logic [7:0]          rd_data,
   input  logic                rd_data_vld,
   output logic [8*NUM_CH-1:0] ch_data,
   output logic [NUM_CH-1:0]   ch_upd,
   output logic                busy,
   output logic                timeout_err,
   output logic                overrun_err
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_REQ, S_WAIT_RD, S_CAPTURE, S_GAP_WAIT, S_NEXT
   } state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     div_cnt;
   logic [TW-1:0]     to_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [1:0]        ch;
   logic [NUM_CH-1:0] mask_q;
   logic              real_pass;
   logic              skip;
   logic              abort;
   logic              pulse_seen;

   logic              tick;
   logic              start;
   logic              second_vld;
   logic              tmo_hit;
   logic              gap_done;
   logic              cap_real;
   logic [1:0]        first_ch;
   logic [1:0]        next_ch;
   logic              next_found;

   assign tick       = en && (div_cnt == DW'(SCAN_DIV - 1));
   assign start      = (state == S_IDLE) && tick && (|ch_mask);
   assign second_vld = (state == S_WAIT_RD) && rd_data_vld && pulse_seen;
   assign tmo_hit    = (state == S_WAIT_RD) && !second_vld && (to_cnt == TW'(TIMEOUT));
   assign gap_done   = (gap_cnt == '0);
   assign cap_real   = (state == S_CAPTURE) && real_pass;

   assign device_id  = DEV_ID;
   assign wr_req     = 1'b0;
   assign wr_data    = 8'h00;
   assign wr_data_vld = 1'b0;

   // Descending search so the lowest qualifying index is the one left standing.
   always_comb begin
      first_ch   = 2'd0;
      next_ch    = 2'd0;
      next_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i])
            first_ch = 2'(i);
         if (mask_q[i] && (2'(i) > ch)) begin
            next_ch    = 2'(i);
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rd_req       = 1'b0;
      reg_addr_vld = 1'b0;
      reg_addr     = 8'h00;
      ch_upd       = '0;
      busy         = (state != S_IDLE);
      for (int i = 0; i < NUM_CH; i++)
         ch_upd[i] = cap_real && (ch == 2'(i));
      case (state)
         S_IDLE:     if (start) state_nxt = S_SETUP;
         S_SETUP: begin
            reg_addr_vld = 1'b1;
            reg_addr     = CTRL_BASE | {6'b0, ch};
            state_nxt    = S_REQ;
         end
         S_REQ: begin
            rd_req    = 1'b1;
            state_nxt = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (second_vld)   state_nxt = S_CAPTURE;
            else if (tmo_hit) state_nxt = S_GAP_WAIT;
         end
         S_CAPTURE:  state_nxt = S_GAP_WAIT;
         S_GAP_WAIT: begin
            if (gap_done) begin
               if (abort || !en)             state_nxt = S_IDLE;
               else if (!real_pass && !skip) state_nxt = S_SETUP;
               else                          state_nxt = S_NEXT;
            end
         end
         S_NEXT:     state_nxt = (next_found && en && !abort) ? S_SETUP : S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         div_cnt     <= '0;
         to_cnt      <= '0;
         gap_cnt     <= '0;
         ch          <= 2'd0;
         mask_q      <= '0;
         real_pass   <= 1'b0;
         skip        <= 1'b0;
         abort       <= 1'b0;
         pulse_seen  <= 1'b0;
         ch_data     <= '0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         state <= state_nxt;

         if (!en || tick) div_cnt <= '0;
         else             div_cnt <= div_cnt + 1'b1;

         // Remember an enable drop so the scan ends after the current transaction.
         if (state != S_IDLE && !en) abort <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  mask_q    <= ch_mask;
                  ch        <= first_ch;
                  real_pass <= 1'b0;
                  skip      <= 1'b0;
                  abort     <= 1'b0;
               end
            end
            S_REQ: begin
               pulse_seen <= 1'b0;
               to_cnt     <= '0;
            end
            S_WAIT_RD: begin
               if (rd_data_vld) pulse_seen <= 1'b1;
               if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
               if (tmo_hit) begin
                  skip    <= 1'b1;
                  gap_cnt <= GW'(GAP - 1);
               end
            end
            S_CAPTURE: begin
               for (int i = 0; i < NUM_CH; i++)
                  if (real_pass && ch == 2'(i)) ch_data[8*i +: 8] <= rd_data;
               gap_cnt <= GW'(GAP - 1);
            end
            S_GAP_WAIT: begin
               if (!gap_done)                gap_cnt   <= gap_cnt - 1'b1;
               else if (!real_pass && !skip) real_pass <= 1'b1;
            end
            S_NEXT: begin
               ch        <= next_ch;
               real_pass <= 1'b0;
               skip      <= 1'b0;
            end
            default: ;
         endcase

         // A set event in the same cycle as err_clr wins.
         if (tmo_hit)      timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
         if (tick && state != S_IDLE) overrun_err <= 1'b1;
         else if (err_clr)            overrun_err <= 1'b0;
      end
   end

endmodule
